ghost_chaser: RTL and testbench

//  Parametrised chasing-enemy sprite, successor of the single top-zone ghost.

---
 rtl/ghost_chaser.sv | 181 ++++++++++++++++++
 tb/tb_ghost_chaser.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/ghost_chaser.sv
// ghost_chaser: chasing-enemy sprite. Follows Yoshi inside a vertical zone,
// walks home when he leaves, respawns and waits after a catch, and streams
// colour-keyed pixels from an external synchronous sprite ROM.
module ghost_chaser #(
  parameter int          SPRITE_W    = 16,
  parameter int          SPRITE_H    = 16,
  parameter int          FRAMES      = 2,
  parameter int          START_X     = 608,
  parameter int          START_Y     = 17,
  parameter int          ZONE_Y_MAX  = 231,
  parameter int          TICK_BASE   = 4600000,
  parameter int          STEP        = 1,
  parameter int          ANIM_PERIOD = 20000000,
  parameter int          HOLD_TICKS  = 64,
  parameter logic [11:0] KEY_COLOR   = 12'h6DE,
  parameter int          MAX_X       = 640,
  parameter int          MAX_Y       = 480,
  localparam int         A           = $clog2(FRAMES*SPRITE_W*SPRITE_H)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [9:0]   y_x,
  input  logic [9:0]   y_y,
  input  logic [9:0]   x,
  input  logic [9:0]   y,
  input  logic [25:0]  speed_offset,
  output logic [A-1:0] rom_addr,
  input  logic [11:0]  rom_data,
  output logic [9:0]   g_x,
  output logic [9:0]   g_y,
  output logic [1:0]   state,
  output logic         caught,
  output logic         ghost_on,
  output logic [11:0]  rgb_out
);

  typedef enum logic [1:0] {HOME = 2'd0, CHASE = 2'd1, RETURN = 2'd2, HOLD = 2'd3} st_t;

  localparam int FW  = (FRAMES > 1) ? $clog2(FRAMES) : 1;
  localparam int HW  = $clog2(HOLD_TICKS + 1);
  localparam int CBW = $clog2(SPRITE_W);
  localparam int RBW = $clog2(SPRITE_H);

  localparam logic [9:0]         SX     = 10'(START_X);
  localparam logic [9:0]         SY     = 10'(START_Y);
  localparam logic [9:0]         LIM_X  = 10'(MAX_X - SPRITE_W);
  localparam logic [9:0]         LIM_Y  = 10'(MAX_Y - SPRITE_H);
  localparam logic [10:0]        W11    = 11'(SPRITE_W);
  localparam logic [10:0]        H11    = 11'(SPRITE_H);
  localparam logic signed [10:0] STEP_S = 11'(STEP);
  localparam logic [31:0]        TB32   = 32'(TICK_BASE);
  localparam logic [HW-1:0]      HOLD_N = HW'(HOLD_TICKS);

  st_t           st;
  logic [31:0]   tick_cnt, period, anim_cnt;
  logic          tick, in_zone, at_start, overlap, moving, facing_left, in_box_d;
  logic [HW-1:0] hold_cnt;
  logic [FW-1:0] frame;
  logic [9:0]    tgt_x, tgt_y, nx, ny;
  logic [10:0]   dx, dy;
  logic [CBW-1:0] col;
  logic [RBW-1:0] row;
  logic          in_box;

  // One axis step toward tgt: full STEP, snap when closer than STEP, then clamp.
  function automatic logic [9:0] step_to(input logic [9:0] cur, input logic [9:0] tgt,
                                         input logic [9:0] lim);
    logic signed [10:0] d, n;
    d = $signed({1'b0, tgt}) - $signed({1'b0, cur});
    if (d >= STEP_S)       n = $signed({1'b0, cur}) + STEP_S;
    else if (d <= -STEP_S) n = $signed({1'b0, cur}) - STEP_S;
    else                   n = $signed({1'b0, tgt});
    if (n < 11'sd0)                     n = 11'sd0;
    else if (n > $signed({1'b0, lim}))  n = $signed({1'b0, lim});
    return n[9:0];
  endfunction

  // Tick period, motion targets, zone and catch detection.
  always_comb begin
    period   = ({6'd0, speed_offset} >= TB32) ? 32'd1 : TB32 - {6'd0, speed_offset};
    tick     = tick_cnt >= period - 32'd1;
    in_zone  = y_y <= 10'(ZONE_Y_MAX);
    at_start = (g_x == SX) && (g_y == SY);
    overlap  = ({1'b0, g_x} < {1'b0, y_x} + W11) && ({1'b0, y_x} < {1'b0, g_x} + W11) &&
               ({1'b0, g_y} < {1'b0, y_y} + H11) && ({1'b0, y_y} < {1'b0, g_y} + H11);
    tgt_x    = (st == CHASE) ? y_x : SX;
    tgt_y    = (st == CHASE) ? y_y : SY;
    nx       = step_to(g_x, tgt_x, LIM_X);
    ny       = step_to(g_y, tgt_y, LIM_Y);
    moving   = tick && (((st == CHASE) && !overlap) || (st == RETURN));
  end

  // Free-running motion tick counter; wraps immediately if P shrinks below it.
  always_ff @(posedge clk) begin
    if (reset || tick) tick_cnt <= '0;
    else               tick_cnt <= tick_cnt + 32'd1;
  end

  // Behaviour FSM with position, facing, hold count and catch pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      st          <= HOME;
      g_x         <= SX;
      g_y         <= SY;
      facing_left <= 1'b0;
      hold_cnt    <= '0;
      caught      <= 1'b0;
    end else begin
      caught <= 1'b0;
      case (st)
        HOME:   if (in_zone) st <= CHASE;
        CHASE: begin
          if (overlap) begin
            caught   <= 1'b1;
            g_x      <= SX;
            g_y      <= SY;
            hold_cnt <= '0;
            st       <= HOLD;
          end else if (!in_zone) begin
            st <= RETURN;
          end
        end
        RETURN: begin
          if (in_zone)       st <= CHASE;
          else if (at_start) st <= HOME;
        end
        HOLD: begin
          g_x <= SX;
          g_y <= SY;
          if (hold_cnt >= HOLD_N) begin
            hold_cnt <= '0;
            st       <= in_zone ? CHASE : HOME;
          end else if (tick) begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: st <= HOME;
      endcase
      if (moving) begin
        g_x <= nx;
        g_y <= ny;
        if (nx < g_x)      facing_left <= 1'b1;
        else if (nx > g_x) facing_left <= 1'b0;
      end
    end
  end

  // Animation runs only while chasing; any other state parks on frame 0.
  always_ff @(posedge clk) begin
    if (reset || st != CHASE) begin
      anim_cnt <= '0;
      frame    <= '0;
    end else if (anim_cnt >= 32'(ANIM_PERIOD - 1)) begin
      anim_cnt <= '0;
      frame    <= (frame == FW'(FRAMES - 1)) ? '0 : frame + 1'b1;
    end else begin
      anim_cnt <= anim_cnt + 32'd1;
    end
  end

  // Sprite-relative coordinates and ROM address; column mirrors when facing left.
  always_comb begin
    dx       = {1'b0, x} - {1'b0, g_x};
    dy       = {1'b0, y} - {1'b0, g_y};
    in_box   = (x >= g_x) && (dx < W11) && (y >= g_y) && (dy < H11);
    col      = facing_left ? CBW'(SPRITE_W - 1) - dx[CBW-1:0] : dx[CBW-1:0];
    row      = dy[RBW-1:0];
    rom_addr = A'(32'(frame) * (SPRITE_W*SPRITE_H) + 32'(row) * SPRITE_W + 32'(col));
  end

  // Delay in_box one clk so it lines up with the synchronous ROM word.
  always_ff @(posedge clk) begin
    if (reset) in_box_d <= 1'b0;
    else       in_box_d <= in_box;
  end

  assign state    = st;
  assign rgb_out  = in_box_d ? rom_data : 12'h000;
  assign ghost_on = in_box_d && (rom_data != KEY_COLOR);

endmodule

// File: tb/tb_ghost_chaser.sv
// Directed bench for ghost_chaser: reset, chase/catch/hold timing, return
// home, fast ticks with snapping, counter wrap on shrinking period, and the
// colour-keyed pixel path with both facings.
module tb_ghost_chaser;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [9:0]  y_x, y_y, x, y;
  logic [25:0] speed_offset;
  logic [8:0]  rom_addr, rom_addr2;
  logic [11:0] rom_data, rom_data2, rgb_out, rgb_out2;
  logic [9:0]  g_x, g_y, g_x2, g_y2;
  logic [1:0]  state, state2;
  logic        caught, caught2, ghost_on, ghost_on2;

  ghost_chaser #(.TICK_BASE(10)) dut (
    .clk(clk), .reset(reset), .y_x(y_x), .y_y(y_y), .x(x), .y(y),
    .speed_offset(speed_offset), .rom_addr(rom_addr), .rom_data(rom_data),
    .g_x(g_x), .g_y(g_y), .state(state), .caught(caught),
    .ghost_on(ghost_on), .rgb_out(rgb_out));

  ghost_chaser #(.TICK_BASE(10), .STEP(4)) dut2 (
    .clk(clk), .reset(reset), .y_x(y_x), .y_y(y_y), .x(x), .y(y),
    .speed_offset(speed_offset), .rom_addr(rom_addr2), .rom_data(rom_data2),
    .g_x(g_x2), .g_y(g_y2), .state(state2), .caught(caught2),
    .ghost_on(ghost_on2), .rgb_out(rgb_out2));

  // Sprite ROM image: column 0 red, column 15 key colour, else encodes frame/row/col.
  function automatic logic [11:0] rom_val(input logic [8:0] a);
    if (a[3:0] == 4'd0)  return 12'hF00;
    if (a[3:0] == 4'd15) return 12'h6DE;
    return {3'b001, a[8], a[7:4], a[3:0]};
  endfunction

  always @(posedge clk) begin
    rom_data  <= rom_val(rom_addr);
    rom_data2 <= rom_val(rom_addr2);
  end

  int errs = 0, checks = 0, cyc = 0;
  int t0, tc;

  typedef struct {
    logic [9:0]  px, py;
    logic [11:0] rgb;
    logic        on;
  } pix_t;
  pix_t tbl [7];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic clk1;
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  initial begin
    // facing LEFT at (608,17): columns are mirrored
    tbl[0] = '{10'd608, 10'd17, 12'h6DE, 1'b0};
    tbl[1] = '{10'd623, 10'd17, 12'hF00, 1'b1};
    tbl[2] = '{10'd610, 10'd20, 12'h23D, 1'b1};
    tbl[3] = '{10'd615, 10'd32, 12'h2F8, 1'b1};
    tbl[4] = '{10'd607, 10'd17, 12'h000, 1'b0};
    tbl[5] = '{10'd624, 10'd17, 12'h000, 1'b0};
    tbl[6] = '{10'd608, 10'd33, 12'h000, 1'b0};

    reset = 1'b1; y_x = 10'd100; y_y = 10'd300; x = '0; y = '0; speed_offset = '0;
    @(negedge clk);
    clk1; clk1;
    chk("rst g_x", g_x, 608);
    chk("rst g_y", g_y, 17);
    chk("rst state", state, 0);
    chk("rst caught", caught, 0);
    chk("rst ghost_on", ghost_on, 0);
    chk("rst rgb", rgb_out, 0);
    chk("rst g_x2", g_x2, 608);

    // Yoshi out of zone: stays home for 10 ticks
    reset = 1'b0;
    repeat (100) clk1;
    chk("home state", state, 0);
    chk("home g_x", g_x, 608);
    chk("home g_y", g_y, 17);

    // Chase toward (580,20); first tick lands after 10 clks
    y_x = 10'd580; y_y = 10'd20; t0 = cyc;
    clk1;
    chk("chase entry", state, 1);
    repeat (8) clk1;
    chk("g_x before tick", g_x, 608);
    clk1;
    chk("g_x first tick", g_x, 607);
    chk("g_y first tick", g_y, 18);
    while (!caught && cyc - t0 < 400) clk1;
    chk("catch cycle", cyc - t0, 131);
    chk("caught pulse", caught, 1);
    chk("catch g_x", g_x, 608);
    chk("catch g_y", g_y, 17);
    chk("catch state", state, 3);
    tc = cyc;
    clk1;
    chk("caught one clk", caught, 0);

    // Pixel path while parked in HOLD, facing left
    for (int i = 0; i < 7; i++) begin
      x = tbl[i].px; y = tbl[i].py;
      clk1;
      chk($sformatf("pix%0d rgb", i), rgb_out, tbl[i].rgb);
      chk($sformatf("pix%0d on", i), ghost_on, tbl[i].on);
    end
    x = '0; y = '0;

    // HOLD lasts 64 ticks, then chase resumes
    while (state != 2'd1 && cyc - tc < 800) clk1;
    chk("hold length", cyc - tc, 640);
    chk("hold exit state", state, 1);

    // Leave the zone: return and arrive home exactly at start
    while (g_x != 10'd606 && cyc - tc < 1000) clk1;
    y_y = 10'd232;
    clk1;
    chk("return entry", state, 2);
    t0 = cyc;
    while (state != 2'd0 && cyc - t0 < 200) clk1;
    chk("home again", state, 0);
    chk("home at x", g_x, 608);
    chk("home at y", g_y, 17);

    // Re-enter zone during RETURN
    y_y = 10'd20;
    clk1;
    chk("rechase", state, 1);
    t0 = cyc;
    while (g_x != 10'd607 && cyc - t0 < 50) clk1;
    y_y = 10'd300;
    clk1;
    chk("return 2", state, 2);
    y_y = 10'd20;
    clk1;
    chk("reenter chase", state, 1);

    // Immediate catch, then reset mid-HOLD
    y_x = 10'd600;
    clk1;
    chk("catch2 pulse", caught, 1);
    chk("catch2 state", state, 3);
    repeat (300) clk1;
    chk("still hold", state, 3);
    reset = 1'b1;
    clk1;
    chk("midrst state", state, 0);
    chk("midrst g_x", g_x, 608);
    chk("midrst g_y", g_y, 17);
    chk("midrst caught", caught, 0);
    chk("midrst on", ghost_on, 0);

    // Tick every clk (P clamps to 1); STEP=4 snaps the 2 px y gap
    speed_offset = 26'd50; y_x = 10'd400; y_y = 10'd19;
    clk1;
    reset = 1'b0;
    clk1;
    chk("fast chase", state, 1);
    chk("fast chase2", state2, 1);
    clk1;
    chk("s1 g_x", g_x, 607);   chk("s1 g_y", g_y, 18);
    chk("s4 g_x", g_x2, 604);  chk("s4 g_y snap", g_y2, 19);
    clk1;
    chk("s1 g_x b", g_x, 606); chk("s1 g_y b", g_y, 19);
    chk("s4 g_x b", g_x2, 600); chk("s4 g_y b", g_y2, 19);

    // Counter at 6 wraps on the next clk once P shrinks to 2
    speed_offset = 26'd0;
    repeat (6) clk1;
    chk("no tick g_x", g_x, 606);
    chk("no tick g_x2", g_x2, 600);
    speed_offset = 26'd8;
    clk1;
    chk("wrap tick g_x", g_x, 605);
    chk("wrap tick g_x2", g_x2, 596);

    // Move right, then check unmirrored pixels
    y_x = 10'd630; speed_offset = 26'd50;
    clk1;
    chk("right g_x", g_x, 606);
    chk("right g_x2", g_x2, 600);
    speed_offset = 26'd0;
    x = 10'd606; y = 10'd19;
    clk1;
    chk("R col0 rgb", rgb_out, 12'hF00);
    chk("R col0 on", ghost_on, 1);
    chk("R dut2 rgb", rgb_out2, 12'h206);
    x = 10'd621;
    clk1;
    chk("R col15 rgb", rgb_out, 12'h6DE);
    chk("R col15 on", ghost_on, 0);
    x = 10'd613; y = 10'd21;
    clk1;
    chk("R mid rgb", rgb_out, 12'h227);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
